// File: rtl/branch_compare_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// branch_compare_seq: MSB-first sliced branch comparator with funct3 decode.
// Revision: 1.0
// ============================================================================
module branch_compare_seq #(
  parameter int N     = 32,
  parameter int CHUNK = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] DataA,
  input  logic [N-1:0] DataB,
  input  logic [2:0]   funct3,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         BrEq,
  output logic         BrLT,
  output logic         taken,
  output logic         illegal
);

  localparam int c_SLICES = N / CHUNK;
  localparam int c_IDX_W  = (c_SLICES > 1) ? $clog2(c_SLICES) : 1;

  localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(c_SLICES - 1);
  localparam logic [CHUNK-1:0]   c_MSB  = CHUNK'(1) << (CHUNK - 1);

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_RUN  = 2'd1;
  localparam logic [1:0] c_ST_DONE = 2'd2;

  generate
    if ((CHUNK < 1) || (CHUNK > N) || ((N % CHUNK) != 0)) begin : g_bad_param
      $error("branch_compare_seq: CHUNK must divide N and satisfy 1 <= CHUNK <= N");
    end
  endgenerate

  logic [1:0]         state_q, state_d;
  logic [c_IDX_W-1:0] idx_q, idx_d;
  logic [N-1:0]       a_q, a_d;
  logic [N-1:0]       b_q, b_d;
  logic [2:0]         f3_q, f3_d;
  logic               breq_q, breq_d;
  logic               brlt_q, brlt_d;
  logic               taken_q, taken_d;
  logic               illegal_q, illegal_d;

  logic [N-1:0]       w_a_sh, w_b_sh;
  logic [CHUNK-1:0]   w_a_cmp, w_b_cmp;
  logic               w_last, w_signed, w_flip;
  logic               w_diff, w_lt;
  logic               w_res_eq, w_res_lt, w_res_taken, w_res_ill;

  assign w_last   = (idx_q == c_LAST);
  // Only BLTU/BGEU are unsigned; the reserved encodings compare signed.
  assign w_signed = ~(f3_q[2] & f3_q[1]);
  assign w_flip   = w_last & w_signed;

  assign w_a_sh  = a_q >> (32'(idx_q) * CHUNK);
  assign w_b_sh  = b_q >> (32'(idx_q) * CHUNK);
  assign w_a_cmp = w_a_sh[CHUNK-1:0] ^ (w_flip ? c_MSB : '0);
  assign w_b_cmp = w_b_sh[CHUNK-1:0] ^ (w_flip ? c_MSB : '0);

  assign w_diff   = (w_a_cmp != w_b_cmp);
  assign w_lt     = (w_a_cmp < w_b_cmp);
  assign w_res_eq = ~w_diff;
  assign w_res_lt = w_diff & w_lt;
  assign w_res_ill = (f3_q[2:1] == 2'b01);

  always_comb begin
    w_res_taken = 1'b0;
    case (f3_q)
      3'b000:         w_res_taken = w_res_eq;
      3'b001:         w_res_taken = ~w_res_eq;
      3'b100, 3'b110: w_res_taken = w_res_lt;
      3'b101, 3'b111: w_res_taken = ~w_res_lt;
      default:        w_res_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    a_d       = a_q;
    b_d       = b_q;
    f3_d      = f3_q;
    breq_d    = breq_q;
    brlt_d    = brlt_q;
    taken_d   = taken_q;
    illegal_d = illegal_q;
    case (state_q)
      c_ST_IDLE: begin
        if (in_valid) begin
          a_d     = DataA;
          b_d     = DataB;
          f3_d    = funct3;
          idx_d   = c_LAST;
          state_d = c_ST_RUN;
        end
      end
      c_ST_RUN: begin
        if (w_diff || (idx_q == '0)) begin
          breq_d    = w_res_eq;
          brlt_d    = w_res_lt;
          taken_d   = w_res_taken;
          illegal_d = w_res_ill;
          state_d   = c_ST_DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      c_ST_DONE: begin
        if (out_ready) begin
          state_d = c_ST_IDLE;
        end
      end
      default: state_d = c_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= c_ST_IDLE;
      idx_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      f3_q      <= '0;
      breq_q    <= 1'b0;
      brlt_q    <= 1'b0;
      taken_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      a_q       <= a_d;
      b_q       <= b_d;
      f3_q      <= f3_d;
      breq_q    <= breq_d;
      brlt_q    <= brlt_d;
      taken_q   <= taken_d;
      illegal_q <= illegal_d;
    end
  end

  assign in_ready  = (state_q == c_ST_IDLE);
  assign out_valid = (state_q == c_ST_DONE);
  assign BrEq      = breq_q;
  assign BrLT      = brlt_q;
  assign taken     = taken_q;
  assign illegal   = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_compare_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_branch_compare_seq: table-driven scoreboard bench for branch_compare_seq.
// Revision: 1.0
// ============================================================================
module tb_branch_compare_seq;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  f3;
    logic        eq;
    logic        lt;
    logic        tk;
    logic        ill;
    int          lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] DataA = '0;
  logic [31:0] DataB = '0;
  logic [2:0]  funct3 = '0;
  logic        sel = 1'b0;

  logic ir0, ov0, eq0, lt0, tk0, il0;
  logic ir1, ov1, eq1, lt1, tk1, il1;
  logic cur_in_ready, cur_out_valid, cur_eq, cur_lt, cur_tk, cur_ill;

  int n_checks = 0;
  int n_err    = 0;
  vec_t vecs[12];
  vec_t sb[$];

  always #5 clk = ~clk;

  branch_compare_seq #(.N(32), .CHUNK(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid & ~sel), .in_ready(ir0),
    .DataA(DataA), .DataB(DataB), .funct3(funct3),
    .out_valid(ov0), .out_ready(out_ready & ~sel),
    .BrEq(eq0), .BrLT(lt0), .taken(tk0), .illegal(il0)
  );

  branch_compare_seq #(.N(32), .CHUNK(32)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid & sel), .in_ready(ir1),
    .DataA(DataA), .DataB(DataB), .funct3(funct3),
    .out_valid(ov1), .out_ready(out_ready & sel),
    .BrEq(eq1), .BrLT(lt1), .taken(tk1), .illegal(il1)
  );

  assign cur_in_ready  = sel ? ir1 : ir0;
  assign cur_out_valid = sel ? ov1 : ov0;
  assign cur_eq        = sel ? eq1 : eq0;
  assign cur_lt        = sel ? lt1 : lt0;
  assign cur_tk        = sel ? tk1 : tk0;
  assign cur_ill       = sel ? il1 : il0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (sel=%0d): got %0h expected %0h", name, sel, act, exp);
    end
  endtask

  task automatic issue(input vec_t v, input int lat);
    vec_t e;
    @(negedge clk);
    chk("in_ready_idle", 32'(cur_in_ready), 32'd1);
    DataA    = v.a;
    DataB    = v.b;
    funct3   = v.f3;
    in_valid = 1'b1;
    e        = v;
    e.lat    = lat;
    sb.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic collect(input int hold);
    vec_t e;
    int   cnt = 0;
    while (!cur_out_valid && cnt < 40) begin
      @(posedge clk);
      #1 cnt++;
    end
    if (!cur_out_valid) begin
      n_checks++;
      n_err++;
      $display("FAIL timeout (sel=%0d): out_valid low after %0d cycles", sel, cnt);
      sb.delete();
      return;
    end
    if (sb.size() == 0) begin
      n_checks++;
      n_err++;
      $display("FAIL unexpected_output (sel=%0d): scoreboard empty", sel);
      return;
    end
    e = sb.pop_front();
    chk("latency", 32'(cnt), 32'(e.lat));
    chk("BrEq", 32'(cur_eq), 32'(e.eq));
    chk("BrLT", 32'(cur_lt), 32'(e.lt));
    chk("taken", 32'(cur_tk), 32'(e.tk));
    chk("illegal", 32'(cur_ill), 32'(e.ill));
    chk("in_ready_done", 32'(cur_in_ready), 32'd0);
    // Backpressure: stray in_valid pulses must be ignored while results hold.
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      in_valid = 1'b1;
      DataA    = ~e.a;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("hold_valid", 32'(cur_out_valid), 32'd1);
      chk("hold_in_ready", 32'(cur_in_ready), 32'd0);
      chk("hold_out", {28'd0, cur_eq, cur_lt, cur_tk, cur_ill}, {28'd0, e.eq, e.lt, e.tk, e.ill});
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("release_valid", 32'(cur_out_valid), 32'd0);
    chk("release_in_ready", 32'(cur_in_ready), 32'd1);
  endtask

  initial begin
    vecs[0]  = '{32'h80000000, 32'h00000001, 3'b100, 1'b0, 1'b1, 1'b1, 1'b0, 1};
    vecs[1]  = '{32'h80000000, 32'h00000001, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    vecs[2]  = '{32'h12345678, 32'h12345678, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 4};
    vecs[3]  = '{32'h12345678, 32'h12345678, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 4};
    vecs[4]  = '{32'h000000FF, 32'h00000100, 3'b111, 1'b0, 1'b1, 1'b0, 1'b0, 3};
    vecs[5]  = '{32'hFFFFFFFF, 32'h00000000, 3'b101, 1'b0, 1'b1, 1'b0, 1'b0, 1};
    vecs[6]  = '{32'h00000001, 32'h00000002, 3'b010, 1'b0, 1'b1, 1'b0, 1'b1, 4};
    vecs[7]  = '{32'h00000000, 32'h00000000, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 4};
    vecs[8]  = '{32'h00000005, 32'h00000003, 3'b101, 1'b0, 1'b0, 1'b1, 1'b0, 4};
    vecs[9]  = '{32'h7FFFFFFF, 32'h80000000, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    vecs[10] = '{32'hFFFFFFFF, 32'h00000001, 3'b011, 1'b0, 1'b1, 1'b0, 1'b1, 1};
    vecs[11] = '{32'h00010000, 32'h00000000, 3'b001, 1'b0, 1'b0, 1'b1, 1'b0, 2};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready8", 32'(ir0), 32'd1);
    chk("rst_out8", {27'd0, ov0, eq0, lt0, tk0, il0}, 32'd0);
    chk("rst_in_ready32", 32'(ir1), 32'd1);
    chk("rst_out32", {27'd0, ov1, eq1, lt1, tk1, il1}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    sel = 1'b0;
    for (int i = 0; i < 12; i++) begin
      issue(vecs[i], vecs[i].lat);
      collect((i == 2) ? 5 : 0);
    end

    // Reset in the second RUN cycle discards the operation.
    issue('{32'h55555555, 32'h55555555, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 4}, 4);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrun_rst_valid", 32'(cur_out_valid), 32'd0);
    chk("midrun_rst_in_ready", 32'(cur_in_ready), 32'd1);
    chk("midrun_rst_out", {29'd0, cur_eq, cur_tk, cur_ill}, 32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1 chk("post_rst_quiet", 32'(cur_out_valid), 32'd0);
    end
    issue(vecs[7], 4);
    collect(0);

    sel = 1'b1;
    for (int i = 0; i < 12; i++) begin
      issue(vecs[i], 1);
      collect((i == 5) ? 2 : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
